// File: rtl/cpc_bus_master.sv
// Z80-style bus initiator for the CPC expansion port: BUSRQ/BUSACK handshake, one memory/IO cycle.
// Define BUS_HOLD_EN to retain the bus for HOLD_CYCLES idle cycles after each transfer.
module cpc_bus_master #(
    parameter int unsigned REQ_TIMEOUT = 1023,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_io,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        BUSRQ_B,
    input  logic        BUSACK_B,
    input  logic        READY,
    output logic [15:0] A_O,
    input  logic [7:0]  D_I,
    output logic [7:0]  D_O,
    output logic        D_OE,
    output logic        BUS_OE,
    output logic        MREQ_B,
    output logic        IOREQ_B,
    output logic        RD_B,
    output logic        WR_B
);

    // One counter serves both the grant timeout and the hold window.
    localparam int unsigned CntMax = (REQ_TIMEOUT > HOLD_CYCLES) ? REQ_TIMEOUT : HOLD_CYCLES;
    localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(REQ_TIMEOUT - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StT1   = 3'd2;
    localparam logic [2:0] StT2   = 3'd3;
    localparam logic [2:0] StTw   = 3'd4;
    localparam logic [2:0] StT3   = 3'd5;
    localparam logic [2:0] StRel  = 3'd6;
    localparam logic [2:0] StHold = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            write_q, write_d;
    logic            io_q, io_d;
    logic            err_q, err_d;

    logic ready_state;
    logic accept;
    logic in_cycle;
    logic strobe_on;
    logic retain;

`ifdef BUS_HOLD_EN
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    assign ready_state = (state_q == StIdle) || (state_q == StHold);
    assign retain      = ((state_q == StRel) && !err_q) || (state_q == StHold);
`else
    assign ready_state = (state_q == StIdle);
    assign retain      = 1'b0;
`endif

    assign cmd_ready = RESET_B && ready_state;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        io_d    = io_q;
        err_d   = err_q;

        if (accept) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            write_d = cmd_write;
            io_d    = cmd_io;
            err_d   = 1'b0;
            cnt_d   = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StReq;
            end
            StReq: begin
                if (!BUSACK_B) begin
                    state_d = StT1;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StRel;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StT1: state_d = StT2;
            StT2, StTw: state_d = READY ? StT3 : StTw;
            StT3: begin
                state_d = StRel;
                if (!write_q) rdata_d = D_I;
            end
            StRel: begin
`ifdef BUS_HOLD_EN
                state_d = err_q ? StIdle : StHold;
                cnt_d   = '0;
`else
                state_d = StIdle;
`endif
            end
            StHold: begin
`ifdef BUS_HOLD_EN
                if (accept) begin
                    state_d = StT1;
                end else if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_B) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            io_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            io_q    <= io_d;
            err_q   <= err_d;
        end
    end

    // Bus pins decode straight from registered state so reset clears them on its own edge.
    assign in_cycle  = (state_q == StT1) || (state_q == StT2) || (state_q == StTw) ||
                       (state_q == StT3);
    assign strobe_on = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);

    assign BUS_OE  = in_cycle || retain;
    assign BUSRQ_B = !((state_q == StReq) || in_cycle || retain);
    assign D_OE    = in_cycle && write_q;
    assign A_O     = BUS_OE ? addr_q : 16'h0000;
    assign D_O     = D_OE ? wdata_q : 8'h00;
    assign MREQ_B  = !(strobe_on && !io_q);
    assign IOREQ_B = !(strobe_on && io_q);
    assign RD_B    = !(strobe_on && !write_q);
    assign WR_B    = !(strobe_on && write_q);

    assign rsp_valid = (state_q == StRel);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_cpc_bus_master.sv
// Directed bench for cpc_bus_master; expectations are hand-derived cycle counts and values.
// Define BUS_HOLD_EN for both files to exercise bus retention.
module tb_cpc_bus_master;

    logic        CLK = 1'b0;
    logic        RESET_B;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_io;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        BUSRQ_B, BUSACK_B, READY;
    logic [15:0] A_O;
    logic [7:0]  D_I, D_O;
    logic        D_OE, BUS_OE, MREQ_B, IOREQ_B, RD_B, WR_B;

`ifdef BUS_HOLD_EN
    localparam int HoldX = 1;
`else
    localparam int HoldX = 0;
`endif

    cpc_bus_master #(
        .REQ_TIMEOUT(8),
        .HOLD_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RESET_B  (RESET_B),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_io   (cmd_io),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .BUSRQ_B  (BUSRQ_B),
        .BUSACK_B (BUSACK_B),
        .READY    (READY),
        .A_O      (A_O),
        .D_I      (D_I),
        .D_O      (D_O),
        .D_OE     (D_OE),
        .BUS_OE   (BUS_OE),
        .MREQ_B   (MREQ_B),
        .IOREQ_B  (IOREQ_B),
        .RD_B     (RD_B),
        .WR_B     (WR_B)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_bad = 0;

    int resp_k, mreq_lo, ioreq_lo, rd_lo, wr_lo, doe_hi, oe_hi, busrq_lo, ready_hi;
    int dout_bad, aout_bad;
    logic       err_seen, busrq_next, ready_next;
    logic [7:0] rdata_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // req_cyc is 1 when the bus must be requested, 0 when accepted from hold.
    task automatic run_cmd(input logic wr, input logic io, input logic [15:0] addr,
                           input logic [7:0] wd, input int waits, input logic [7:0] rd_val,
                           input int req_cyc);
        bit acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_io    = io;
        cmd_addr  = addr;
        cmd_wdata = wd;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge CLK);
            acc = cmd_ready;
            @(posedge CLK);
            #1;
        end
        cmd_valid = 1'b0;
        resp_k = -1; mreq_lo = 0; ioreq_lo = 0; rd_lo = 0; wr_lo = 0; doe_hi = 0;
        oe_hi = 0; busrq_lo = 0; ready_hi = 0; dout_bad = 0; aout_bad = 0;
        err_seen = 1'b0; rdata_seen = 8'h00;
        if (!acc) begin
            chk("accept", 32'd0, 32'd1);
        end else begin
            for (int k = 1; k <= 40; k++) begin
                READY = !(k >= 2 + req_cyc && k < 2 + req_cyc + waits);
                D_I   = (k == 3 + req_cyc + waits) ? rd_val : 8'h00;
                @(negedge CLK);
                mreq_lo  += int'(!MREQ_B);
                ioreq_lo += int'(!IOREQ_B);
                rd_lo    += int'(!RD_B);
                wr_lo    += int'(!WR_B);
                doe_hi   += int'(D_OE);
                oe_hi    += int'(BUS_OE);
                busrq_lo += int'(!BUSRQ_B);
                ready_hi += int'(cmd_ready);
                if (D_OE && D_O !== wd) dout_bad++;
                if (BUS_OE && A_O !== addr) aout_bad++;
                if (rsp_valid) begin
                    resp_k     = k;
                    err_seen   = rsp_err;
                    rdata_seen = rsp_rdata;
                end
                @(posedge CLK);
                #1;
                if (resp_k >= 0) break;
            end
        end
        READY = 1'b1;
        D_I   = 8'h00;
        @(negedge CLK);
        busrq_next = BUSRQ_B;
        ready_next = cmd_ready;
    endtask

    initial begin
        int rv;
        int lo;
        RESET_B = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_io = 1'b0;
        cmd_addr = 16'h0000; cmd_wdata = 8'h00; BUSACK_B = 1'b0; READY = 1'b1; D_I = 8'h00;

        wait_cycles(3);
        @(negedge CLK);
        chk("rst_strobes", 32'({BUSRQ_B, MREQ_B, IOREQ_B, RD_B, WR_B}), 32'h1f);
        chk("rst_oe", 32'({BUS_OE, D_OE}), 32'h0);
        chk("rst_addr", 32'(A_O), 32'h0);
        chk("rst_dout", 32'(D_O), 32'h0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        @(posedge CLK);
        #1;
        RESET_B = 1'b1;

        // Memory read, no waits.
        run_cmd(1'b0, 1'b0, 16'h4000, 8'h00, 0, 8'hA5, 1);
        chk("rd_latency", 32'(resp_k), 32'd5);
        chk("rd_mreq", 32'(mreq_lo), 32'd2);
        chk("rd_rd", 32'(rd_lo), 32'd2);
        chk("rd_other", 32'(ioreq_lo + wr_lo + doe_hi), 32'd0);
        chk("rd_data", 32'(rdata_seen), 32'hA5);
        chk("rd_err", 32'(err_seen), 32'd0);
        chk("rd_addr", 32'(aout_bad), 32'd0);
        chk("rd_busrq", 32'(busrq_lo), 32'(4 + HoldX));
        chk("rd_busy_ready", 32'(ready_hi), 32'd0);
        chk("rd_after_busrq", 32'(busrq_next), 32'(1 - HoldX));
        chk("rd_after_ready", 32'(ready_next), 32'd1);
        wait_cycles(8);

        // IO write.
        run_cmd(1'b1, 1'b1, 16'h7FC4, 8'hC2, 0, 8'h00, 1);
        chk("iow_latency", 32'(resp_k), 32'd5);
        chk("iow_ioreq", 32'(ioreq_lo), 32'd2);
        chk("iow_wr", 32'(wr_lo), 32'd2);
        chk("iow_mreq", 32'(mreq_lo + rd_lo), 32'd0);
        chk("iow_doe", 32'(doe_hi), 32'd3);
        chk("iow_dout", 32'(dout_bad), 32'd0);
        chk("iow_oe", 32'(oe_hi), 32'(3 + HoldX));
        chk("iow_rdata_kept", 32'(rdata_seen), 32'hA5);
        wait_cycles(8);

        // Memory write with three wait states.
        run_cmd(1'b1, 1'b0, 16'h1234, 8'h5A, 3, 8'h00, 1);
        chk("ws_latency", 32'(resp_k), 32'd8);
        chk("ws_wr", 32'(wr_lo), 32'd5);
        chk("ws_mreq", 32'(mreq_lo), 32'd5);
        chk("ws_doe", 32'(doe_hi), 32'd6);
        chk("ws_dout", 32'(dout_bad), 32'd0);
        chk("ws_busrq", 32'(busrq_lo), 32'(7 + HoldX));
        wait_cycles(8);

        // Grant never arrives.
        BUSACK_B = 1'b1;
        run_cmd(1'b0, 1'b0, 16'hBEEF, 8'h00, 0, 8'h77, 1);
        chk("to_latency", 32'(resp_k), 32'd9);
        chk("to_err", 32'(err_seen), 32'd1);
        chk("to_strobes", 32'(mreq_lo + ioreq_lo + rd_lo + wr_lo + oe_hi), 32'd0);
        chk("to_busrq", 32'(busrq_lo), 32'd8);
        chk("to_after_busrq", 32'(busrq_next), 32'd1);
        chk("to_rdata_kept", 32'(rdata_seen), 32'hA5);
        BUSACK_B = 1'b0;
        wait_cycles(2);

        // Reset while stuck in wait states.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_io = 1'b0; cmd_addr = 16'h2222; READY = 1'b0;
        @(negedge CLK);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        wait_cycles(4);
        @(negedge CLK);
        chk("mid_in_tw", 32'({MREQ_B, RD_B, BUSRQ_B}), 32'h0);
        RESET_B = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_strobes", 32'({BUSRQ_B, MREQ_B, IOREQ_B, RD_B, WR_B}), 32'h1f);
        chk("mid_oe", 32'({BUS_OE, D_OE, rsp_valid}), 32'h0);
        RESET_B = 1'b1;
        READY = 1'b1;
        rv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            rv += int'(rsp_valid) + int'(!BUSRQ_B);
        end
        chk("mid_quiet", 32'(rv), 32'd0);
        @(posedge CLK);
        #1;

        run_cmd(1'b0, 1'b0, 16'h0100, 8'h00, 0, 8'h3C, 1);
        chk("post_latency", 32'(resp_k), 32'd5);
        chk("post_data", 32'(rdata_seen), 32'h3C);
        chk("post_err", 32'(err_seen), 32'd0);

`ifdef BUS_HOLD_EN
        wait_cycles(8);
        run_cmd(1'b0, 1'b0, 16'h5000, 8'h00, 0, 8'h11, 1);
        chk("hold_first_data", 32'(rdata_seen), 32'h11);
        chk("hold_kept", 32'(busrq_next), 32'd0);
        run_cmd(1'b0, 1'b0, 16'h5001, 8'h00, 0, 8'h22, 0);
        chk("hold_latency", 32'(resp_k), 32'd4);
        chk("hold_busrq", 32'(busrq_lo), 32'd4);
        chk("hold_data", 32'(rdata_seen), 32'h22);
        lo = int'(!busrq_next);
        for (int i = 0; i < 20 && !BUSRQ_B; i++) begin
            @(negedge CLK);
            lo += int'(!BUSRQ_B);
        end
        chk("hold_release", 32'(lo), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
